// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums a frame of COUNT unsigned products coming from the 2x2 multiplier and
// presents the frame total on a valid/ready output. The total is held until
// the consumer takes it. Together with the multiplier, this forms a
// multiply-accumulate (dot-product) path.
//
// Ports
//   clk        rising-edge clock, the only clock
//   rst        synchronous, active-high reset (wins over every other input)
//   clr        synchronous frame abort; drops partial sums and any held frame
//   in_prod    product M from the multiplier, unsigned, PWIDTH bits
//   in_valid   in_prod is valid this cycle
//   in_ready   block accepts in_prod this cycle (high in ACC)
//   out_sum    frame total modulo 2^SWIDTH
//   out_ovf    frame total exceeded 2^SWIDTH-1 (qualified by out_valid)
//   out_valid  out_sum/out_ovf hold a completed frame (high in HOLD)
//   out_ready  consumer takes the frame this cycle
//   state_dbg  current FSM state (0 = ACC, 1 = HOLD)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. Once valid is raised, the sender keeps it and its data stable until
// that edge. in_ready and out_valid are decoded only from the registered
// state, so nothing combinational passes from in_valid or out_ready. A beat
// offered in a cycle with clr=1 is dropped, even though in_ready reads 1.
// -----------------------------------------------------------------------------
module product_accumulator #(
   parameter int PWIDTH = 4,
   parameter int COUNT  = 4,
   parameter int SWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [PWIDTH-1:0] in_prod,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [SWIDTH-1:0] out_sum,
   output logic              out_ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              state_dbg
);

   localparam int CNT_W = $clog2(COUNT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

   if (COUNT < 2 || COUNT > 255) begin : g_bad_count
      $error("product_accumulator: COUNT must be in 2..255");
   end
   if (PWIDTH > SWIDTH) begin : g_bad_width
      $error("product_accumulator: PWIDTH must not exceed SWIDTH");
   end

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t            state_q;
   logic [SWIDTH-1:0] acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ovf_q;
   logic [SWIDTH-1:0] sum_q;
   logic              sum_ovf_q;

   // One bit wider than the accumulator so that the top bit is the carry-out
   // of this add.
   logic [SWIDTH:0]   sum_ext;
   logic              last_beat;

   always_comb begin
      sum_ext   = {1'b0, acc_q} + {{(SWIDTH + 1 - PWIDTH){1'b0}}, in_prod};
      last_beat = (cnt_q == LAST_CNT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_ACC;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         sum_q     <= '0;
         sum_ovf_q <= 1'b0;
      end else if (clr) begin
         // Abort: drop partial sums and any held frame. The visible out_sum
         // is left unchanged; it is not qualified once out_valid falls.
         state_q <= ST_ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_ACC: begin
               if (in_valid) begin
                  if (last_beat) begin
                     // The final product goes straight to the output
                     // registers. The running state restarts for the next
                     // frame.
                     sum_q     <= sum_ext[SWIDTH-1:0];
                     sum_ovf_q <= ovf_q | sum_ext[SWIDTH];
                     acc_q     <= '0;
                     cnt_q     <= '0;
                     ovf_q     <= 1'b0;
                     state_q   <= ST_HOLD;
                  end else begin
                     acc_q <= sum_ext[SWIDTH-1:0];
                     ovf_q <= ovf_q | sum_ext[SWIDTH];
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_q <= ST_ACC;
               end
            end
            default: begin
               state_q <= ST_ACC;
            end
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == ST_ACC);
      out_valid = (state_q == ST_HOLD);
      out_sum   = sum_q;
      out_ovf   = sum_ovf_q;
      state_dbg = state_q;
   end

endmodule
